// File: rtl/word_receiver.sv
// Serial-to-parallel receiver for the exchange word link: frames MSB-first bits
// into WIDTH-bit words, rejects short/long frames and buffers good words in a FWFT FIFO.
module word_receiver #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          datain,
  input  logic                          comEn,
  output logic [WIDTH-1:0]              word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {SYNC, IDLE, SHIFT, ST_END} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shreg;
  logic [CW-1:0]     bitcnt;
  logic              shift_en, commit, err_det, last_bit, start;

  logic [WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, rd_en, wr_en;

  assign last_bit = (bitcnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (!comEn) state_nxt = IDLE;
      IDLE:    if (comEn)  state_nxt = SHIFT;
      SHIFT:   if (!comEn) state_nxt = IDLE;
               else if (last_bit) state_nxt = ST_END;
      ST_END:  state_nxt = comEn ? SYNC : IDLE;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    start    = (state == IDLE) && comEn;
    shift_en = (state == SHIFT) && comEn;
    commit   = (state == ST_END) && !comEn;
    err_det  = ((state == SHIFT) && !comEn) || ((state == ST_END) && comEn);
  end

  // Shift register and bit counter; the lead cycle clears the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (start) begin
      bitcnt <= '0;
    end else if (shift_en) begin
      shreg  <= {shreg[WIDTH-2:0], datain};
      bitcnt <= bitcnt + 1'b1;
    end
  end

  // FIFO: a read on the commit cycle frees the slot the write needs.
  assign full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign rd_en = word_valid && word_ready;
  assign wr_en = commit && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err <= err_det;
      overflow  <= commit && full && !rd_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    word_valid = (fifo_count != '0);
    word_out   = word_valid ? mem[rd_ptr] : '0;
  end

endmodule
